// File: rtl/mips_core_pkg.sv
// Shared core types and widths used by the multiplier writeback path.
package mips_core_pkg;

  localparam int ROB_PTR_W   = 5;
  localparam int GPR_PTR_W   = 6;
  localparam int HILO_PTR_W  = 2;
  localparam int WB_Y_W      = 64;
  localparam int MUL_LATENCY = 3;

  // One writeback result as held in the queue and presented to the arbiter.
  typedef struct packed {
    logic [ROB_PTR_W-1:0]  rob_ptr;
    logic                  gpr_val;
    logic [GPR_PTR_W-1:0]  gpr_ptr;
    logic                  hilo_val;
    logic [HILO_PTR_W-1:0] hilo_ptr;
    logic [WB_Y_W-1:0]     y;
  } wb_entry_t;

endpackage

// File: rtl/wb_entry_fifo.sv
// DEPTH-entry in-order storage for writeback results: head/tail/count with
// push, pop and flush. A pop and a push in the same cycle are both honoured,
// including when full. Head data reads as zero while empty.
module wb_entry_fifo
  import mips_core_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  wb_entry_t              push_data,
  input  logic                   pop,
  output wb_entry_t              head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  wb_entry_t     mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy tracking; flush empties the queue in one edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Entry storage; contents are only observable through the valid head.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[tail] <= push_data;
  end

  // Present the head entry, zeroed while empty so idle outputs read 0.
  always_comb begin
    head_data = '0;
    if (!empty) head_data = mem[head];
  end

endmodule

// File: rtl/mul_wb_queue.sv
// Writeback holding queue behind the fixed-latency multiplier. Captures every
// unkilled completion, drains in order to the writeback arbiter, issues
// credit so captures are never lost, and discards work on ROB flush.
// Optional feature macro: MUL_WB_BYPASS_EN (same-cycle bypass when empty).
module mul_wb_queue
  import mips_core_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int MUL_LAT = MUL_LATENCY
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  mul_go,
  output logic                  mul_can_issue,
  input  logic                  in_complete,
  input  logic [ROB_PTR_W-1:0]  in_rob_ptr,
  input  logic                  in_gpr_val,
  input  logic [GPR_PTR_W-1:0]  in_gpr_ptr,
  input  logic                  in_hilo_val,
  input  logic [HILO_PTR_W-1:0] in_hilo_ptr,
  input  logic [WB_Y_W-1:0]     in_y,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [ROB_PTR_W-1:0]  wb_rob_ptr,
  output logic                  wb_gpr_val,
  output logic [GPR_PTR_W-1:0]  wb_gpr_ptr,
  output logic                  wb_hilo_val,
  output logic [HILO_PTR_W-1:0] wb_hilo_ptr,
  output logic [WB_Y_W-1:0]     wb_y,
  output logic                  overflow
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int IF_W  = $clog2(MUL_LAT + 1);
  localparam int SUM_W = $clog2(DEPTH + MUL_LAT + 1) + 1;

  logic [MUL_LAT-1:0] go_sr;
  logic [MUL_LAT-1:0] kill_sr;
  logic [IF_W-1:0]    inflight;
  logic               capture;
  wb_entry_t          in_entry;
  wb_entry_t          head_data;
  wb_entry_t          wb_data;
  logic [CNT_W-1:0]   count;
  logic               fifo_empty;
  logic               fifo_full;
  logic               fifo_push;
  logic               fifo_pop;

  assign in_entry = '{rob_ptr: in_rob_ptr, gpr_val: in_gpr_val, gpr_ptr: in_gpr_ptr,
                      hilo_val: in_hilo_val, hilo_ptr: in_hilo_ptr, y: in_y};

  // Slot MUL_LAT-1 of the trackers is the op completing this cycle.
  assign capture = in_complete && !kill_sr[MUL_LAT-1] && !flush;

  // In-flight tracker: one bit per issue cycle; on flush every live slot,
  // including this cycle's go, is tagged killed and ages out with its op.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      go_sr   <= '0;
      kill_sr <= '0;
    end else begin
      go_sr <= MUL_LAT'({go_sr, mul_go});
      if (flush) kill_sr <= MUL_LAT'({go_sr, mul_go});
      else       kill_sr <= MUL_LAT'({kill_sr, 1'b0});
    end
  end

  // Count outstanding ops, killed ones included, so credit frees only as they drain.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < MUL_LAT; i++) begin
      inflight = inflight + IF_W'(go_sr[i]);
    end
  end

  // Credit uses registered occupancy; a pop this cycle returns credit next cycle.
  assign mul_can_issue = (SUM_W'(count) + SUM_W'(inflight)) < SUM_W'(DEPTH);

`ifdef MUL_WB_BYPASS_EN
  // Empty queue forwards an unkilled result straight through; it is only
  // stored if the arbiter does not take it this cycle.
  always_comb begin
    wb_valid  = !fifo_empty || capture;
    wb_data   = fifo_empty ? in_entry : head_data;
    fifo_pop  = !fifo_empty && wb_ready;
    fifo_push = capture && !(fifo_empty && wb_ready);
  end
`else
  // Registered-only path: results appear the cycle after capture.
  always_comb begin
    wb_valid  = !fifo_empty;
    wb_data   = head_data;
    fifo_pop  = !fifo_empty && wb_ready;
    fifo_push = capture;
  end
`endif

  // Fan the presented entry out to the writeback port fields.
  always_comb begin
    wb_rob_ptr  = wb_data.rob_ptr;
    wb_gpr_val  = wb_data.gpr_val;
    wb_gpr_ptr  = wb_data.gpr_ptr;
    wb_hilo_val = wb_data.hilo_val;
    wb_hilo_ptr = wb_data.hilo_ptr;
    wb_y        = wb_data.y;
  end

  // Sticky record of a capture arriving with no room (issue credit broken).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (fifo_push && fifo_full && !fifo_pop) begin
      overflow <= 1'b1;
    end
  end

  wb_entry_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (fifo_push),
    .push_data (in_entry),
    .pop       (fifo_pop),
    .head_data (head_data),
    .count     (count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_mul_wb_queue.sv
// Scoreboard bench for mul_wb_queue: stimulus pushes expected writebacks,
// a negedge monitor pops and compares every accepted wb_* transfer.
module tb_mul_wb_queue;
  import mips_core_pkg::*;

`ifdef MUL_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  flush = 1'b0;
  logic                  mul_go = 1'b0;
  logic                  mul_can_issue;
  logic                  in_complete = 1'b0;
  logic [ROB_PTR_W-1:0]  in_rob_ptr = '0;
  logic                  in_gpr_val = 1'b0;
  logic [GPR_PTR_W-1:0]  in_gpr_ptr = '0;
  logic                  in_hilo_val = 1'b0;
  logic [HILO_PTR_W-1:0] in_hilo_ptr = '0;
  logic [WB_Y_W-1:0]     in_y = '0;
  logic                  wb_valid;
  logic                  wb_ready = 1'b0;
  logic [ROB_PTR_W-1:0]  wb_rob_ptr;
  logic                  wb_gpr_val;
  logic [GPR_PTR_W-1:0]  wb_gpr_ptr;
  logic                  wb_hilo_val;
  logic [HILO_PTR_W-1:0] wb_hilo_ptr;
  logic [WB_Y_W-1:0]     wb_y;
  logic                  overflow;

  always #5 clk = ~clk;

  mul_wb_queue #(.DEPTH(4), .MUL_LAT(3)) dut (
    .clk(clk), .reset(reset), .flush(flush), .mul_go(mul_go),
    .mul_can_issue(mul_can_issue), .in_complete(in_complete),
    .in_rob_ptr(in_rob_ptr), .in_gpr_val(in_gpr_val), .in_gpr_ptr(in_gpr_ptr),
    .in_hilo_val(in_hilo_val), .in_hilo_ptr(in_hilo_ptr), .in_y(in_y),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rob_ptr(wb_rob_ptr),
    .wb_gpr_val(wb_gpr_val), .wb_gpr_ptr(wb_gpr_ptr), .wb_hilo_val(wb_hilo_val),
    .wb_hilo_ptr(wb_hilo_ptr), .wb_y(wb_y), .overflow(overflow)
  );

  wb_entry_t exp_q[$];
  int        checks = 0;
  int        fails  = 0;

  // Bench model of the 3-stage multiplier: go in cycle N completes in N+3.
  bit        pv[3];
  wb_entry_t pe[3];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic wb_entry_t mk(input int n);
    wb_entry_t   e;
    logic [31:0] v;
    v          = n;
    e.rob_ptr  = v[4:0];
    e.gpr_val  = v[0];
    e.gpr_ptr  = v[5:0] + 6'd7;
    e.hilo_val = ~v[0];
    e.hilo_ptr = v[1:0];
    e.y        = {32'hC0DE0000 | v, ~v};
    return e;
  endfunction

  task automatic drive_in(input logic c, input wb_entry_t e);
    in_complete = c;
    in_rob_ptr  = e.rob_ptr;
    in_gpr_val  = e.gpr_val;
    in_gpr_ptr  = e.gpr_ptr;
    in_hilo_val = e.hilo_val;
    in_hilo_ptr = e.hilo_ptr;
    in_y        = e.y;
  endtask

  // One clock with optional issue; completions come from the model pipeline.
  task automatic tick(input bit go, input wb_entry_t e, input bit expect_it);
    mul_go = go;
    if (go && expect_it) exp_q.push_back(e);
    @(posedge clk); #1;
    pv[2] = pv[1]; pe[2] = pe[1];
    pv[1] = pv[0]; pe[1] = pe[0];
    pv[0] = go;    pe[0] = e;
    drive_in(pv[2], pe[2]);
    mul_go = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, '0, 1'b0);
  endtask

  // Completion injected directly (pipeline must be empty), for fill/overflow cases.
  task automatic force_cycle(input wb_entry_t e, input bit expect_it);
    drive_in(1'b1, e);
    if (expect_it) exp_q.push_back(e);
    @(posedge clk); #1;
    drive_in(1'b0, '0);
  endtask

  task automatic drain(input string name, input int bound);
    for (int k = 0; k < bound && exp_q.size() != 0; k++) tick(1'b0, '0, 1'b0);
    chk({"drain_", name}, 128'(exp_q.size()), 128'(0));
  endtask

  // Monitor: every accepted transfer must be the oldest expected entry.
  always @(negedge clk) begin
    wb_entry_t act;
    wb_entry_t e;
    if (reset && wb_valid && wb_ready) begin
      act = {wb_rob_ptr, wb_gpr_val, wb_gpr_ptr, wb_hilo_val, wb_hilo_ptr, wb_y};
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_pop actual=%0h required=none", act);
      end else begin
        e = exp_q.pop_front();
        chk("wb_entry", 128'(act), 128'(e));
      end
    end
  end

  initial begin
    int issued;
    // reset state
    #2;
    chk("rst_wb_valid", 128'(wb_valid), 128'(0));
    chk("rst_wb_y", 128'(wb_y), 128'(0));
    chk("rst_overflow", 128'(overflow), 128'(0));
    chk("rst_can_issue", 128'(mul_can_issue), 128'(1));
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // 1 back-to-back issue with ready held high
    wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t1_can_issue", 128'(mul_can_issue), 128'(1));
      if (i == 3) chk("t1_latency_c3", 128'(wb_valid), 128'(BYP));
      tick(1'b1, mk(i), 1'b1);
    end
    chk("t1_valid_c4", 128'(wb_valid), 128'(1));
    drain("t1", 20);
    idle(2);

    // 2 backpressure until credit runs out
    wb_ready = 1'b0;
    issued = 0;
    for (int k = 0; k < 10 && mul_can_issue; k++) begin
      tick(1'b1, mk(10 + k), 1'b1);
      issued++;
    end
    chk("t2_issued", 128'(issued), 128'(4));
    idle(4);
    chk("t2_can_issue_full", 128'(mul_can_issue), 128'(0));
    chk("t2_overflow", 128'(overflow), 128'(0));
    chk("t2_valid", 128'(wb_valid), 128'(1));
    wb_ready = 1'b1;
    drain("t2", 12);
    chk("t2_credit_back", 128'(mul_can_issue), 128'(1));

    // 3 push and pop together while full, across pointer wrap
    wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) force_cycle(mk(20 + i), 1'b1);
    chk("t3_full_credit", 128'(mul_can_issue), 128'(0));
    wb_ready = 1'b1;
    force_cycle(mk(24), 1'b1);
    chk("t3_still_full_a", 128'(mul_can_issue), 128'(0));
    force_cycle(mk(25), 1'b1);
    chk("t3_still_full_b", 128'(mul_can_issue), 128'(0));
    chk("t3_overflow", 128'(overflow), 128'(0));
    drain("t3", 12);
    idle(1);

    // 4 flush with two queued and two in flight, plus a go in the flush cycle
    wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick(1'b1, mk(30 + i), 1'b0);
    idle(1);
    chk("t4_pre_credit", 128'(mul_can_issue), 128'(0));
    chk("t4_pre_valid", 128'(wb_valid), 128'(1));
    flush = 1'b1;
    tick(1'b1, mk(34), 1'b0);
    flush = 1'b0;
    chk("t4_valid_after", 128'(wb_valid), 128'(0));
    wb_ready = 1'b1;
    idle(1);
    chk("t4_valid_c7", 128'(wb_valid), 128'(0));
    chk("t4_credit", 128'(mul_can_issue), 128'(1));
    idle(4);
    chk("t4_valid_drained", 128'(wb_valid), 128'(0));
    chk("t4_overflow", 128'(overflow), 128'(0));

    // 5 credit violation: fifth capture with queue full is dropped
    wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) force_cycle(mk(40 + i), 1'b1);
    chk("t5_overflow_pre", 128'(overflow), 128'(0));
    force_cycle(mk(44), 1'b0);
    chk("t5_overflow_set", 128'(overflow), 128'(1));
    wb_ready = 1'b1;
    drain("t5", 12);
    idle(2);
    chk("t5_overflow_sticky", 128'(overflow), 128'(1));

    // 6 asynchronous reset in the middle of a drain
    wb_ready = 1'b0;
    for (int i = 0; i < 3; i++) force_cycle(mk(50 + i), 1'b1);
    wb_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_valid", 128'(wb_valid), 128'(0));
    chk("t6_overflow", 128'(overflow), 128'(0));
    chk("t6_can_issue", 128'(mul_can_issue), 128'(1));
    chk("t6_wb_rob", 128'(wb_rob_ptr), 128'(0));
    wb_ready = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;

    // single result into an empty queue with ready high
    wb_ready = 1'b1;
    drive_in(1'b1, mk(60));
    exp_q.push_back(mk(60));
    #1;
    chk("t6_same_cycle_valid", 128'(wb_valid), 128'(BYP));
    @(posedge clk); #1;
    drive_in(1'b0, '0);
    chk("t6_next_cycle_valid", 128'(wb_valid), 128'(!BYP));
    drain("t6", 6);
    idle(2);
    chk("end_wb_valid", 128'(wb_valid), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
